// File: rtl/step_seq_pkg.sv
// rtl/step_seq_pkg.sv - state codes, direction constants and load legality helper for step_sequence_counter
package step_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_COUNT = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // A value is reachable only if it lies on the STEP grid between START and LIMIT.
    function automatic logic is_legal_value(input int value, input int start,
                                            input int limit, input int step);
        return (value >= start) && (value <= limit) && (((value - start) % step) == 0);
    endfunction

endpackage

// File: rtl/step_seq_next.sv
// rtl/step_seq_next.sv - combinational next-value and wrap detection for step_sequence_counter
module step_seq_next
    import step_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int START = 0,
    parameter int LIMIT = 14,
    parameter int STEP  = 2
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    output logic [WIDTH-1:0] next_val,
    output logic             wrap_hit
);

    localparam logic [WIDTH:0]   START_X = (WIDTH+1)'(START);
    localparam logic [WIDTH:0]   LIMIT_X = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] START_W = WIDTH'(START);
    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

    logic [WIDTH:0]   count_x;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH-1:0] sum_dn;

    assign count_x = {1'b0, count};
    assign sum_up  = count_x + STEP_X;
    assign sum_dn  = count - STEP_W;

    // Terminal detection uses the extra carry bit so LIMIT near 2**WIDTH cannot alias.
    assign wrap_hit = (dir == DIR_DOWN) ? (count_x < START_X + STEP_X) : (sum_up > LIMIT_X);

    always_comb begin
        next_val = sum_up[WIDTH-1:0];
        if (wrap_hit)
            next_val = (dir == DIR_DOWN) ? LIMIT_W : START_W;
        else if (dir == DIR_DOWN)
            next_val = sum_dn;
    end

endmodule

// File: rtl/step_sequence_counter.sv
// rtl/step_sequence_counter.sv - stepping sequence counter; STEP_SEQ_WRAP_COUNT_EN adds a saturating wrap_cnt output
module step_sequence_counter
    import step_seq_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int START   = 0,
    parameter int LIMIT   = 14,
    parameter int STEP    = 2,
    parameter int ONESHOT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             run,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done,
    output logic             err
`ifdef STEP_SEQ_WRAP_COUNT_EN
    ,
    output logic [7:0]       wrap_cnt
`endif
);

    if ((LIMIT <= START) || (LIMIT >= (1 << WIDTH)) || (((LIMIT - START) % STEP) != 0)) begin : g_bad_params
        $error("step_sequence_counter: LIMIT/START/STEP do not form a valid sequence");
    end

    localparam logic [WIDTH-1:0] START_W = WIDTH'(START);
    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    state_t           state;
    logic [WIDTH-1:0] next_val;
    logic             wrap_hit;
    logic             load_ok;
    logic             advance;
    logic             wrap_event;

    step_seq_next #(
        .WIDTH(WIDTH),
        .START(START),
        .LIMIT(LIMIT),
        .STEP (STEP)
    ) u_next (
        .count   (count),
        .dir     (dir),
        .next_val(next_val),
        .wrap_hit(wrap_hit)
    );

    assign load_ok    = is_legal_value(int'(load_val), START, LIMIT, STEP);
    assign advance    = !clear && !load && run && (state != ST_DONE);
    assign wrap_event = advance && wrap_hit && (ONESHOT == 0);

    assign tc   = (dir == DIR_DOWN) ? (count == START_W) : (count == LIMIT_W);
    assign done = (ONESHOT != 0) && (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= START_W;
            state <= ST_IDLE;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            wrap <= wrap_event;
            if (clear) begin
                count <= START_W;
                state <= ST_IDLE;
                err   <= 1'b0;
            end else if (load) begin
                count <= load_ok ? load_val : START_W;
                if (!load_ok)
                    err <= 1'b1;
                state <= ST_HOLD;
            end else if (advance) begin
                // In one-shot mode the terminal value is held and the counter parks in DONE.
                if (wrap_hit && (ONESHOT != 0)) begin
                    state <= ST_DONE;
                end else begin
                    count <= next_val;
                    state <= ST_COUNT;
                end
            end else if (state == ST_COUNT) begin
                state <= ST_HOLD;
            end
        end
    end

`ifdef STEP_SEQ_WRAP_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wrap_cnt <= 8'd0;
        else if (clear)
            wrap_cnt <= 8'd0;
        else if (wrap_event && (wrap_cnt != 8'hFF))
            wrap_cnt <= wrap_cnt + 8'd1;
    end
`endif

endmodule
